// File: rtl/nmix_pkg.sv
// Shared types and helpers for the NMIX stream mixer (optional inverse mode: NMIX_INV_EN).
package nmix_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} nmix_state_e;

    localparam int unsigned NMIX_MIN_WIDTH = 3;

    // Slice-index width; at least 1 bit so a single-slice build still has a counter.
    function automatic int unsigned idx_width(input int unsigned width, input int unsigned bpc);
        int unsigned n;
        n = width / bpc;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nmix_slice.sv
// Combinational BPC-bit NMIX slice; the carry and previous-bit pipes ripple LSB to MSB.
// Inverse recovery is generated only when NMIX_INV_EN is defined.
module nmix_slice
    import nmix_pkg::*;
#(
    parameter int unsigned BPC = 1
) (
    input  logic [BPC-1:0] i_x,
    input  logic [BPC-1:0] i_r,
    input  logic           i_inv,
    input  logic           i_c,
    input  logic           i_xp1,
    input  logic           i_xp2,
    input  logic           i_rp1,
    input  logic           i_rp2,
    output logic [BPC-1:0] o_y,
    output logic           o_c,
    output logic           o_xp1,
    output logic           o_xp2,
    output logic           o_rp1,
    output logic           o_rp2
);

    logic w_c, w_xp1, w_xp2, w_rp1, w_rp2, w_bit, w_xe;

`ifndef NMIX_INV_EN
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
`endif

    always_comb begin
        w_c   = i_c;
        w_xp1 = i_xp1;
        w_xp2 = i_xp2;
        w_rp1 = i_rp1;
        w_rp2 = i_rp2;
        w_bit = 1'b0;
        w_xe  = 1'b0;
        o_y   = '0;
        for (int i = 0; i < int'(BPC); i++) begin
            w_bit  = i_x[i] ^ i_r[i] ^ (w_xp1 & w_xp2) ^ (w_rp1 & w_rp2) ^ w_c;
            o_y[i] = w_bit;
            w_xe   = i_x[i];
`ifdef NMIX_INV_EN
            // In inverse mode the carry and X pipe follow the recovered bit.
            if (i_inv) w_xe = w_bit;
`endif
            w_c   = w_c ^ (w_xe & i_r[i]);
            w_xp2 = w_xp1;
            w_xp1 = w_xe;
            w_rp2 = w_rp1;
            w_rp1 = i_r[i];
        end
        o_c   = w_c;
        o_xp1 = w_xp1;
        o_xp2 = w_xp2;
        o_rp1 = w_rp1;
        o_rp2 = w_rp2;
    end

endmodule

// File: rtl/nmix_stream.sv
// Handshaked NMIX mixer: accepts (X,R), produces Y after WIDTH/BPC cycles.
// Define NMIX_INV_EN to latch in_inv and enable per-operand inverse mode.
module nmix_stream
    import nmix_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] R,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);

    localparam int unsigned   NSlices = WIDTH / BPC;
    localparam int unsigned   IdxW    = idx_width(WIDTH, BPC);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSlices - 1);

    if (WIDTH < NMIX_MIN_WIDTH || (WIDTH % BPC) != 0) begin : g_bad_cfg
        $error("nmix_stream: WIDTH must be >= 3 and a multiple of BPC");
    end

    nmix_state_e       r_state, w_state_nxt;
    logic              r_started, w_accept, w_inv;
    logic [IdxW-1:0]   r_idx;
    logic              r_c, r_xp1, r_xp2, r_rp1, r_rp2;
    logic [WIDTH-1:0]  r_x, r_r, r_y;
    logic [BPC-1:0]    w_y;
    logic              w_c, w_xp1, w_xp2, w_rp1, w_rp2;

`ifdef NMIX_INV_EN
    logic r_inv;
    assign w_inv = r_inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_inv        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = r_started;
                w_accept = in_valid & r_started;
                if (w_accept) w_state_nxt = StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (r_idx == LastIdx) w_state_nxt = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Operands shift down so the current slice always sits at bit 0.
    nmix_slice #(.BPC(BPC)) u_slice (
        .i_x   (r_x[BPC-1:0]),
        .i_r   (r_r[BPC-1:0]),
        .i_inv (w_inv),
        .i_c   (r_c),
        .i_xp1 (r_xp1),
        .i_xp2 (r_xp2),
        .i_rp1 (r_rp1),
        .i_rp2 (r_rp2),
        .o_y   (w_y),
        .o_c   (w_c),
        .o_xp1 (w_xp1),
        .o_xp2 (w_xp2),
        .o_rp1 (w_rp1),
        .o_rp2 (w_rp2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_started <= 1'b0;
            r_idx     <= '0;
            r_c       <= 1'b0;
            r_xp1     <= 1'b0;
            r_xp2     <= 1'b0;
            r_rp1     <= 1'b0;
            r_rp2     <= 1'b0;
            r_x       <= '0;
            r_r       <= '0;
            r_y       <= '0;
`ifdef NMIX_INV_EN
            r_inv     <= 1'b0;
`endif
        end else begin
            r_started <= 1'b1;
            if (w_accept) begin
                r_idx <= '0;
                r_c   <= 1'b0;
                r_xp1 <= 1'b0;
                r_xp2 <= 1'b0;
                r_rp1 <= 1'b0;
                r_rp2 <= 1'b0;
                r_x   <= X;
                r_r   <= R;
                r_y   <= '0;
`ifdef NMIX_INV_EN
                r_inv <= in_inv;
`endif
            end else if (r_state == StRun) begin
                r_idx <= r_idx + 1'b1;
                r_c   <= w_c;
                r_xp1 <= w_xp1;
                r_xp2 <= w_xp2;
                r_rp1 <= w_rp1;
                r_rp2 <= w_rp2;
                r_x   <= r_x >> BPC;
                r_r   <= r_r >> BPC;
                for (int s = 0; s < int'(NSlices); s++) begin
                    if (r_idx == IdxW'(s)) r_y[s*BPC +: BPC] <= w_y;
                end
            end
        end
    end

    assign Y = r_y;

endmodule

// File: tb/tb_nmix_stream.sv
// Directed and model-checked bench for nmix_stream (WIDTH=32, BPC via -G; inverse with NMIX_INV_EN).
module tb_nmix_stream;

    parameter int unsigned BPC = 1;
    localparam int unsigned WIDTH = 32;
    localparam int NCYC = WIDTH / BPC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] X = '0;
    logic [31:0] R = '0;
    logic        in_inv = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Y;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nmix_stream #(.WIDTH(WIDTH), .BPC(BPC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .R         (R),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference built straight from the bit equation; carry recomputed per bit.
    function automatic logic [31:0] nmix_ref(input logic [31:0] a, input logic [31:0] r,
                                             input logic inv);
        logic [31:0] xs, o;
        logic cc, xm1, xm2, rm1, rm2;
        xs = '0;
        o  = '0;
        for (int i = 0; i < 32; i++) begin
            cc = 1'b0;
            for (int j = 0; j < i; j++) cc = cc ^ (xs[j] & r[j]);
            xm1 = (i >= 1) ? xs[i-1] : 1'b0;
            xm2 = (i >= 2) ? xs[i-2] : 1'b0;
            rm1 = (i >= 1) ? r[i-1] : 1'b0;
            rm2 = (i >= 2) ? r[i-2] : 1'b0;
            o[i]  = a[i] ^ r[i] ^ (xm1 & xm2) ^ (rm1 & rm2) ^ cc;
            xs[i] = inv ? o[i] : a[i];
        end
        return o;
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] r, input logic inv);
        int k;
        k = 0;
        X = x;
        R = r;
        in_inv = inv;
        in_valid = 1'b1;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(output logic [31:0] y, output int lat, input int hold);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("done_timeout", {31'b0, out_valid}, 32'd1);
        y = Y;
        repeat (hold) begin
            @(negedge clk);
            check("bp_y_stable", Y, y);
            check("bp_valid_held", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [31:0] y, a, r, e, fwd;
    int          lat;
    logic [31:0] vx[3] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] vy[3] = '{32'h0000_0007, 32'h0000_0003, 32'h0000_0001};

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_y", Y, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("in_ready_before_clk", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("in_ready_after_clk", {31'b0, in_ready}, 32'd1);

        // Basic vector and latency
        send(32'h0000_0001, 32'h0000_0001, 1'b0);
        recv(y, lat, 0);
        check("vec1_y", y, 32'hFFFF_FFFE);
        check("vec1_latency", lat, NCYC);

        // R = 0 vectors
        for (int i = 0; i < 3; i++) begin
            send(vx[i], 32'h0, 1'b0);
            recv(y, lat, 0);
            check("r0_y", y, vy[i]);
        end

        // Back-pressure in DONE with a pending operand
        send(32'hFFFF_FFFF, 32'h0, 1'b0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        X = 32'h0000_0001;
        R = 32'h0;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("hold_y", Y, 32'h0000_0003);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bubble_out_valid", {31'b0, out_valid}, 32'd0);
        check("bubble_in_ready", {31'b0, in_ready}, 32'd1);
        check("bubble_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("pending_accepted", {31'b0, busy}, 32'd1);
        recv(y, lat, 0);
        check("pending_y", y, 32'h0000_0001);

        // Abort with reset at slice 5
        send(32'h0000_0001, 32'h0000_0001, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_abort_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_y", Y, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_abort_in_ready", {31'b0, in_ready}, 32'd1);
        send(32'h0000_0003, 32'h0, 1'b0);
        recv(y, lat, 0);
        check("post_abort_y", y, 32'h0000_0007);

`ifdef NMIX_INV_EN
        // Inverse mode
        send(32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        recv(y, lat, 0);
        check("inv_vec_y", y, 32'h0000_0001);
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            r = $urandom;
            send(a, r, 1'b0);
            recv(fwd, lat, 0);
            send(fwd, r, 1'b1);
            recv(y, lat, 0);
            check("roundtrip_x", y, a);
        end
`endif

        // Random vectors with back-pressure against the reference model
        for (int n = 0; n < 500; n++) begin
            a = $urandom;
            r = $urandom;
            e = nmix_ref(a, r, 1'b0);
            send(a, r, 1'b0);
            recv(y, lat, $urandom_range(0, 3));
            check("rand_y", y, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
